// File: rtl/dl_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output port between NUM_REQ requesters.
// The winner's payload lands in a single-entry buffer tagged with its source index.
module dl_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 32,
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_mask,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [ID_W-1:0]             out_id,
  input  logic                        out_ready
);

  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_ptr;

  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_hi_mask;
  logic [NUM_REQ-1:0]  w_hi;
  logic [ID_W-1:0]     w_hi_idx;
  logic [ID_W-1:0]     w_lo_idx;
  logic [ID_W-1:0]     w_win;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_any;
  logic                w_load_ok;
  logic                w_xfer;

  assign w_elig    = req_valid & req_mask;
  assign w_any     = |w_elig;
  assign w_load_ok = !r_valid || out_ready;
  // rst_n gates the handshake so nothing is accepted while reset is held
  assign w_xfer    = w_load_ok && w_any && rst_n;

  // Winner: lowest eligible index at or above ptr, else lowest eligible overall
  always_comb begin
    w_hi_mask = '0;
    w_hi_idx  = '0;
    w_lo_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_hi_mask[i] = (ID_W'(i) >= r_ptr);
    end
    w_hi = w_elig & w_hi_mask;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_hi[i])   w_hi_idx = ID_W'(i);
      if (w_elig[i]) w_lo_idx = ID_W'(i);
    end
    w_win = (|w_hi) ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_win_data = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_win_data   = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = w_xfer;
      end
    end
  end

  // Output buffer and priority pointer; a simultaneous drain and load replaces the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_win_data;
      r_id    <= w_win;
      r_ptr   <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_id;

endmodule

// File: doc/dl_rr_arbiter.md
# dl_rr_arbiter

Parameterized round-robin arbiter that shares one downstream valid/ready port between NUM_REQ upstream requesters. It registers the winning requester's payload in a single-entry output buffer, tags it with the source index, and rotates priority after every accepted transfer. It sits in the design library as the generic sharing point for a common datapath resource, such as a register-file write port or a memory request port.

## Interface
- NUM_REQ, 4: number of requesters; ≥1.
- DATA_W, 32: payload width per requester.
- ID_W, max($clog2(NUM_REQ),1): width of out_id; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_mask  input  NUM_REQ  1 = requester eligible; a masked requester is never granted.
- req_ready  output  NUM_REQ  one-hot or zero; transfer from i when req_valid[i] && req_ready[i].
- out_valid  output  1  output buffer holds a payload.
- out_data  output  DATA_W  buffered payload.
- out_id  output  ID_W  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts when out_valid && out_ready.

## Operation
- Eligible set E = req_valid & req_mask.
- Pointer ptr (ID_W bits) marks the highest-priority index. Winner = first set bit of E scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
- Buffer can load when load_ok = !out_valid || out_ready.
- req_ready[winner] = load_ok && (E != 0). All other req_ready bits are 0. req_ready may depend combinationally on req_valid, req_mask, and out_ready, but never on req_data.
- On a transfer from winner w: out_data <= req_data[w], out_id <= w, out_valid <= 1, ptr <= (w == NUM_REQ-1) ? 0 : w+1.
- With no transfer and out_valid && out_ready, out_valid <= 0. out_data and out_id hold their last values.
- With no transfer and no drain, all state holds. ptr changes only on an accepted transfer.
- Simultaneous drain and load in the same cycle: the buffer is replaced with the new payload, and out_valid stays 1. This gives full throughput of 1 transfer per cycle.
- Fairness: a requester held valid and unmasked is granted within NUM_REQ-1 other transfers.
- Requesters must hold req_valid and req_data stable until accepted. The arbiter does not depend on this; it re-evaluates the winner every cycle.
- NUM_REQ=1: ptr stays 0. The block degenerates to a one-entry register slice gated by req_mask[0].

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_id=0, ptr=0.
- While rst_n is low, req_ready=0.
- A reset asserted mid-operation discards any buffered payload. No partial transfer is reported.
- Deassertion of rst_n is treated as synchronous to clk by the integrator.
- Latency: a payload accepted at edge N appears on out_valid/out_data/out_id after edge N, i.e. 1 cycle.
- out_valid, out_data, and out_id are register outputs with no combinational path from inputs.
- When out_valid=1 and out_ready=0, all req_ready bits are 0 (backpressure). The buffer contents are held stable until the drain.
- A masked requester that is valid sees req_ready=0 and does not advance ptr.

## Test plan
- Reset then idle: rst_n low for 3 cycles, then high with all req_valid=0 → out_valid=0, out_id=0, out_data=0, req_ready=0000 every cycle.
- Round-robin rotation: NUM_REQ=4, req_valid=1111, req_data[i]=0xA0+i, mask=1111, out_ready=1 for 8 cycles → out_id sequence 0,1,2,3,0,1,2,3 with out_data 0xA0..0xA3 repeating, one per cycle after a 1-cycle latency.
- Backpressure: buffer holds id 2 / 0xA2 and out_ready=0 for 5 cycles while req_valid=1011 → req_ready=0000, out_data remains 0xA2. On out_ready=1, the next grant goes to id 3 (ptr=3), then id 0.
- Masking and skip: req_valid=1111, req_mask=0101, ptr=1 → grants alternate 2,0,2,0. Requesters 1 and 3 never see req_ready=1.
- Simultaneous drain and load: out_valid=1 (id 0), out_ready=1, req_valid=0010 → in the same cycle req_ready=0010. The next cycle out_id=1 with out_valid continuously 1.
- Async reset mid-transfer: out_valid=1 with ptr=3, then drive rst_n low between clock edges → out_valid=0 and out_id=0 immediately with no clock edge. After release with req_valid=1111, the first grant is id 0.
